// File: rtl/aibcr3_str_drv.sv
// Strobe launcher: frames a burst of full strobe periods between a quiet
// preamble and a quiet postamble, and reports done / abort / dropped requests.
//
// Ports:
//   clk        launch clock, all state updates on its rising edge
//   reset_n    asynchronous active-low reset
//   str_en     block enable; low forces IDLE (abort if a burst is running)
//   req        burst request, sampled on the rising edge of clk
//   burst_len  number of full strobe periods, latched on acceptance
//   clr_err    clears req_drop on the next edge
//   str_out    registered strobe to the pad path
//   busy       high from acceptance until done or abort
//   done       one-cycle pulse on normal completion
//   abort      one-cycle pulse when str_en drops mid-burst
//   req_drop   sticky flag: a request arrived while busy
module aibcr3_str_drv #(
    parameter int CNT_W    = 8,
    parameter int PRE_CYC  = 2,
    parameter int POST_CYC = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             str_en,
    input  logic             req,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             clr_err,
    output logic             str_out,
    output logic             busy,
    output logic             done,
    output logic             abort,
    output logic             req_drop
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        BURST = 2'd2,
        POST  = 2'd3
    } state_t;

    localparam logic [3:0]     PRE_LD  = 4'(PRE_CYC - 1);
    localparam logic [3:0]     POST_LD = 4'(POST_CYC - 1);
    localparam logic [CNT_W:0] PH_ONE  = {{CNT_W{1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    // One bit wider than burst_len so 2*L-1 fits for the largest L.
    logic [CNT_W:0]   ph_q, ph_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             str_q, str_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;
    logic             drop_q, drop_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        len_d   = len_q;
        str_d   = str_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        abort_d = 1'b0;

        // Set has priority over clear.
        drop_d = drop_q;
        if (clr_err) drop_d = 1'b0;
        if (req && state_q != IDLE) drop_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                str_d  = 1'b0;
                busy_d = 1'b0;
                if (req && str_en) begin
                    if (burst_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        len_d   = burst_len;
                        cnt_d   = PRE_LD;
                        busy_d  = 1'b1;
                        state_d = PRE;
                    end
                end
            end
            PRE: begin
                if (cnt_q == 4'd0) begin
                    state_d = BURST;
                    str_d   = 1'b1;
                    // Remaining edges in BURST after the first high phase.
                    ph_d    = {len_q, 1'b0} - PH_ONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            BURST: begin
                if (ph_q == '0) begin
                    state_d = POST;
                    str_d   = 1'b0;
                    cnt_d   = POST_LD;
                end else begin
                    ph_d  = ph_q - PH_ONE;
                    str_d = ~str_q;
                end
            end
            POST: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Losing enable mid-burst overrides any completion in this cycle.
        if (state_q != IDLE && !str_en) begin
            state_d = IDLE;
            str_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            abort_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ph_q    <= '0;
            len_q   <= '0;
            str_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            len_q   <= len_d;
            str_q   <= str_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            drop_q  <= drop_d;
        end
    end

    assign str_out  = str_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign abort    = abort_q;
    assign req_drop = drop_q;

endmodule

// File: doc/aibcr3_str_drv.md
Name: aibcr3_str_drv

Overview:
- Strobe launcher that drives the transmit strobe net terminated by the strobe IO load cell.
- On request, emits a framed strobe burst: a quiet preamble, a programmable number of full toggle periods, then a quiet postamble.
- Flags completion, abort and dropped requests to the adapter-side control logic.
- Sits between the adapter control registers and the strobe pad path.

Parameters:
- CNT_W, 8, width of the burst-length input and the internal burst counter.
- PRE_CYC, 2, preamble length in clk cycles with str_out held low; legal range 1..15.
- POST_CYC, 2, postamble length in clk cycles with str_out held low; legal range 1..15.

Ports:
- clk  input  1  launch clock; all state is updated on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- str_en  input  1  block enable; low forces IDLE.
- req  input  1  burst request, sampled on the rising edge of clk.
- burst_len  input  CNT_W  number of full strobe periods; latched when a request is accepted.
- clr_err  input  1  clears req_drop.
- str_out  output  1  registered strobe to the pad path / IO load net.
- busy  output  1  high from request acceptance until done or abort.
- done  output  1  single-cycle pulse on normal completion.
- abort  output  1  single-cycle pulse when str_en drops mid-burst.
- req_drop  output  1  sticky flag: a request arrived while busy.

Behaviour:
- Reset is asynchronous, active-low. While reset_n=0: str_out=0, busy=0, done=0, abort=0, req_drop=0, state=IDLE, all counters 0.
- All outputs are registered. Clock and reset are named as in the codebase: clk, reset_n.
- States: IDLE, PRE, BURST, POST.
- IDLE:
  - str_out=0.
  - Edge N with req=1, str_en=1, burst_len=L>0: latch L, go to PRE, busy=1 after edge N.
  - Same case with L=0: stay IDLE, done=1 for one cycle, no toggles, busy stays 0.
- PRE: str_out=0 for PRE_CYC cycles. At edge N+PRE_CYC go to BURST and set str_out=1.
- BURST:
  - str_out inverts on every edge for 2L cycles, starting high and ending low.
  - The phase counter is CNT_W+1 bits, so L=2^CNT_W-1 cannot overflow.
  - At edge N+PRE_CYC+2L go to POST with str_out=0.
- POST:
  - str_out=0 for POST_CYC cycles.
  - At edge N+PRE_CYC+2L+POST_CYC go to IDLE with done=1 and busy=0 in the same cycle.
  - done drops on the next edge.
- Back-to-back requests: req=1 in the done cycle is accepted, because the state is then IDLE. Minimum spacing between bursts is therefore one cycle.
- req while busy (PRE/BURST/POST): the request is ignored, req_drop is set, and the running burst is unaffected.
- req_drop clearing:
  - clr_err=1 clears req_drop on the next edge.
  - If a drop and clr_err occur together, set wins.
- str_en=0 in PRE/BURST/POST: at the next edge go to IDLE, str_out=0, busy=0, abort=1 for one cycle, and no done.
- str_en=0 with req=1 in IDLE: nothing happens and req_drop is not set.
- burst_len changes after acceptance have no effect until the next accepted request.
- Asynchronous reset mid-burst: all outputs go to their reset values immediately, without waiting for a clock edge.

Test Plan:
- Basic burst:
  - Stimulus: reset, then str_en=1; req at edge 0 with L=3 (PRE_CYC=2, POST_CYC=2).
  - Required: str_out high after edges 2,4,6 and low after edges 3,5,7; done=1 only after edge 10; busy=1 over edges 0..10.
- Zero length:
  - Stimulus: req with L=0.
  - Required: done=1 for exactly one cycle after the sampling edge; str_out=0 and busy=0 throughout.
- Dropped request:
  - Stimulus: req during BURST, then clr_err 5 cycles later.
  - Required: req_drop=1 from the edge after the req until the clr_err edge; the burst toggle count is unchanged (2L edges).
- Abort:
  - Stimulus: str_en=0 during BURST while str_out=1.
  - Required: after the next edge str_out=0, busy=0, abort one-cycle pulse, done never asserts; a new req then gives a full burst.
- Back-to-back and maximum length:
  - Stimulus: req held high with L=255.
  - Required: exactly 510 toggles per burst; the second burst's PRE starts the edge after done; no counter overflow.
- Asynchronous reset:
  - Stimulus: assert reset_n=0 mid-BURST between clock edges.
  - Required: str_out, busy and flags go to 0 before the next clk edge; after release, state is IDLE.
